// File: rtl/csp_buf1.sv
// One-place buffer for a single-bit CSP channel with clocked four-phase handshakes on both sides.
// Optional protocol checker with proto_err output, compiled in when CSP_BUF1_CHECK_EN is defined.
module csp_buf1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_req,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ack,
    output logic             out_req,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ack
`ifdef CSP_BUF1_CHECK_EN
    ,
    output logic             proto_err
`endif
);

    typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RTZ} out_state_t;

    in_state_t        in_st, in_st_d;
    out_state_t       out_st, out_st_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] out_data_d;
    logic             full, full_d;
    logic             set_full, clr_full;
    logic             in_ack_d, out_req_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_st    <= IN_IDLE;
            out_st   <= OUT_IDLE;
            buf_q    <= '0;
            out_data <= '0;
            full     <= 1'b0;
            in_ack   <= 1'b0;
            out_req  <= 1'b0;
        end else begin
            in_st    <= in_st_d;
            out_st   <= out_st_d;
            buf_q    <= buf_d;
            out_data <= out_data_d;
            full     <= full_d;
            in_ack   <= in_ack_d;
            out_req  <= out_req_d;
        end
    end

    // Input side: capture a token only when the buffer is empty.
    always_comb begin
        in_st_d  = in_st;
        in_ack_d = in_ack;
        buf_d    = buf_q;
        set_full = 1'b0;
        case (in_st)
            IN_IDLE: begin
                if (in_req && !full) begin
                    buf_d    = in_data;
                    set_full = 1'b1;
                    in_ack_d = 1'b1;
                    in_st_d  = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!in_req) begin
                    in_ack_d = 1'b0;
                    in_st_d  = IN_IDLE;
                end
            end
            default: in_st_d = IN_IDLE;
        endcase
    end

    // Output side: offer the held token, free the buffer on the consumer's ack.
    always_comb begin
        out_st_d   = out_st;
        out_req_d  = out_req;
        out_data_d = out_data;
        clr_full   = 1'b0;
        case (out_st)
            OUT_IDLE: begin
                if (full) begin
                    out_data_d = buf_q;
                    out_req_d  = 1'b1;
                    out_st_d   = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (out_ack) begin
                    out_req_d = 1'b0;
                    clr_full  = 1'b1;
                    out_st_d  = OUT_RTZ;
                end
            end
            OUT_RTZ: begin
                if (!out_ack) out_st_d = OUT_IDLE;
            end
            default: out_st_d = OUT_IDLE;
        endcase
    end

    // Clear wins over set so a freed slot is never re-marked full on the same edge.
    always_comb begin
        full_d = full;
        if (set_full) full_d = 1'b1;
        if (clr_full) full_d = 1'b0;
    end

`ifdef CSP_BUF1_CHECK_EN
    logic             in_req_q;
    logic [WIDTH-1:0] in_data_q;
    logic             out_ack_q;
    logic             err_now;

    // Previous-cycle samples let us see edges and changes on the channel wires.
    always_comb begin
        err_now = 1'b0;
        if (in_st == IN_IDLE && !in_ack && in_req_q && !in_req) err_now = 1'b1;
        if (in_req && in_req_q && !in_ack && (in_data != in_data_q)) err_now = 1'b1;
        if (out_ack && !out_ack_q && !out_req && out_st == OUT_IDLE) err_now = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_req_q  <= 1'b0;
            in_data_q <= '0;
            out_ack_q <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            in_req_q  <= in_req;
            in_data_q <= in_data;
            out_ack_q <= out_ack;
            if (err_now) proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_csp_buf1.sv
// Directed self-checking bench for csp_buf1 with an auto-acking recording sink.
// Covers reset, latency, ordering, back-pressure, mid-handshake reset and the optional checker.
module tb_csp_buf1;

    logic       clk;
    logic       reset;
    logic       in_req;
    logic [0:0] in_data;
    logic       in_ack;
    logic       out_req;
    logic [0:0] out_data;
    logic       out_ack;
`ifdef CSP_BUF1_CHECK_EN
    logic       proto_err;
`endif

    int   n_chk;
    int   n_fail;
    logic sink_en;
    logic force_ack;
    logic rec_q[$];

    csp_buf1 #(.WIDTH(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_req   (in_req),
        .in_data  (in_data),
        .in_ack   (in_ack),
        .out_req  (out_req),
        .out_data (out_data),
        .out_ack  (out_ack)
`ifdef CSP_BUF1_CHECK_EN
        ,
        .proto_err(proto_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sink: when enabled, acks one cycle after out_req and records the token.
    initial begin
        out_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!sink_en) out_ack = force_ack;
            else if (out_req && !out_ack) begin
                rec_q.push_back(out_data[0]);
                out_ack = 1'b1;
            end else if (!out_req && out_ack) out_ack = 1'b0;
        end
    end

    task automatic wait_ack(input logic lvl, input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ack == lvl) break;
        end
        chk(tag, in_ack, lvl);
    endtask

    task automatic send(input logic d);
        @(negedge clk);
        in_data = d;
        in_req  = 1'b1;
        wait_ack(1'b1, "send_ack_hi");
        in_req = 1'b0;
        wait_ack(1'b0, "send_ack_lo");
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        sink_en   = 1'b0;
        force_ack = 1'b0;
        reset     = 1'b1;
        in_req    = 1'b0;
        in_data   = 1'b0;

        // Reset state, during and after
        @(negedge clk);
        chk("rst_in_ack", in_ack, 0);
        chk("rst_out_req", out_req, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ack", in_ack, 0);
        chk("post_rst_out_req", out_req, 0);
        chk("post_rst_out_data", out_data, 0);

        // Latency: ack after edge N, out_req after edge N+1
        sink_en = 1'b1;
        in_data = 1'b1;
        in_req  = 1'b1;
        @(negedge clk);
        chk("lat_in_ack_n", in_ack, 1);
        chk("lat_out_req_n", out_req, 0);
        in_req = 1'b0;
        @(negedge clk);
        chk("lat_out_req_n1", out_req, 1);
        chk("lat_in_ack_n1", in_ack, 0);
        chk("lat_out_data", out_data, 1);
        repeat (5) @(negedge clk);
        chk("lat_rec_cnt", rec_q.size(), 1);
        if (rec_q.size() > 0) chk("lat_rec_val", rec_q[0], 1);
        rec_q.delete();

        // Sequence 0,1,1 with 10-cycle gaps
        send(1'b0);
        repeat (10) @(negedge clk);
        send(1'b1);
        repeat (10) @(negedge clk);
        send(1'b1);
        repeat (10) @(negedge clk);
        chk("seq_cnt", rec_q.size(), 3);
        if (rec_q.size() == 3) begin
            chk("seq_0", rec_q[0], 0);
            chk("seq_1", rec_q[1], 1);
            chk("seq_2", rec_q[2], 1);
        end
        rec_q.delete();

        // Back-pressure: consumer stalls with one token held
        sink_en = 1'b0;
        send(1'b0);
        @(negedge clk);
        in_data = 1'b1;
        in_req  = 1'b1;
        repeat (6) @(negedge clk);
        chk("bp_in_ack_held", in_ack, 0);
        chk("bp_out_req", out_req, 1);
        chk("bp_out_data", out_data, 0);
        sink_en = 1'b1;
        wait_ack(1'b1, "bp_accept");
        in_req = 1'b0;
        wait_ack(1'b0, "bp_release");
        repeat (6) @(negedge clk);
        chk("bp_cnt", rec_q.size(), 2);
        if (rec_q.size() == 2) begin
            chk("bp_0", rec_q[0], 0);
            chk("bp_1", rec_q[1], 1);
        end
        rec_q.delete();

        // Mid-handshake reset with in_ack and out_req both high
        sink_en = 1'b0;
        @(negedge clk);
        in_data = 1'b0;
        in_req  = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_pre_in_ack", in_ack, 1);
        chk("mr_pre_out_req", out_req, 1);
        reset = 1'b1;
        #1;
        chk("mr_in_ack", in_ack, 0);
        chk("mr_out_req", out_req, 0);
        chk("mr_out_data", out_data, 0);
        @(negedge clk);
        reset   = 1'b0;
        in_req  = 1'b0;
        sink_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_no_stale", rec_q.size(), 0);
        chk("mr_idle_out_req", out_req, 0);
        send(1'b1);
        repeat (6) @(negedge clk);
        chk("mr_cnt", rec_q.size(), 1);
        if (rec_q.size() > 0) chk("mr_val", rec_q[0], 1);
        rec_q.delete();

        // Stray out_ack while idle
`ifdef CSP_BUF1_CHECK_EN
        chk("pe_clean", proto_err, 0);
`endif
        sink_en   = 1'b0;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
`ifdef CSP_BUF1_CHECK_EN
        chk("pe_set", proto_err, 1);
`endif
        chk("stray_out_req", out_req, 0);
        chk("stray_in_ack", in_ack, 0);
        chk("stray_out_data", out_data, 1);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
`ifdef CSP_BUF1_CHECK_EN
        chk("pe_sticky", proto_err, 1);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`ifdef CSP_BUF1_CHECK_EN
        chk("pe_cleared", proto_err, 0);
`endif
        chk("end_out_data", out_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
